mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage of the pipelined CPU.
- Consumes the EX/MEM register outputs and resolves branches: PCSrc = branch & zero.
- Performs data-memory loads and stores against an internal word array with configurable wait states.
- Registers the results into the MEM/WB pipeline register and stalls upstream stages while a multi-cycle access is in flight.

Parameters:
- MEM_WORDS, 256, data-memory depth in 32-bit words; power of two.
- WAIT_CYCLES, 2, extra cycles per load/store (0 = single-cycle access).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- alu_result  input  32  ALU result from EX/MEM; byte address for loads/stores
- store_data  input  32  RD2 from EX/MEM; store data
- wn  input  5  destination register number
- control_W  input  2  WB control: [1] RegWrite, [0] MemtoReg
- branch  input  1  branch instruction in MEM
- zero  input  1  ALU zero flag
- branch_pc  input  32  branch target from EX/MEM
- MemWrite  input  1  store request
- MemRead  input  1  load request
- pcsrc  output  1  take branch: select branch_target in IF
- branch_target  output  32  equals branch_pc (combinational pass-through)
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle
- wb_rd  output  32  registered load data
- wb_alu  output  32  registered alu_result
- wb_wn  output  5  registered destination register
- wb_W  output  2  registered WB control

Behaviour:
- Reset: async on rst high. FSM→IDLE, counter=0, wb_rd=0, wb_alu=0, wb_wn=0, wb_W=0. stall=0 and pcsrc=0 while rst high. Memory contents are not cleared.
- Address: word index = alu_result[log2(MEM_WORDS)+1:2]. Bits [1:0] ignored. Upper bits ignored, so addresses wrap modulo MEM_WORDS*4.
- FSM states: IDLE, WAIT.
- IDLE, access (MemRead|MemWrite) with WAIT_CYCLES>0: stall=1, counter←WAIT_CYCLES-1, →WAIT.
- IDLE, access with WAIT_CYCLES==0, or no access: complete this cycle, stall=0, stay IDLE.
- WAIT: stall=1 while counter!=0; counter decrements each cycle.
- WAIT with counter==0: complete this cycle, stall=0, →IDLE.
- Access latency: WAIT_CYCLES+1 cycles total. stall is high for exactly the first WAIT_CYCLES of them.
- Upstream holds EX/MEM inputs stable while stall=1. This block does not re-sample them.
- Completion cycle, on the clock edge:
  - MEM/WB register loads wb_alu←alu_result, wb_wn←wn, wb_W←control_W.
  - wb_rd←mem[idx] if MemRead, else 0.
  - If MemWrite, mem[idx]←store_data.
- Stall cycles: MEM/WB loads a bubble (wb_W=0; wb_rd, wb_alu, wb_wn hold). This prevents duplicate writeback.
- Non-memory instructions: complete in one cycle, no stall.
- MemRead and MemWrite both high: store performed; wb_rd returns the pre-write contents (read-before-write).
- pcsrc: combinational, = branch & zero & ~stall. Branch instructions never carry MemRead/MemWrite, so pcsrc is never gated in practice.
- Reset mid-access: FSM abandons the access. A pending store is dropped (memory unchanged). stall drops immediately.
- Back-to-back accesses: after a completion cycle in IDLE or WAIT, the next access re-enters WAIT on the following cycle. There are no idle gap cycles.

Test Plan:
- WAIT_CYCLES=2. Store: MemWrite=1, alu_result=0x10, store_data=0xDEADBEEF → stall high 2 cycles, low on 3rd. mem[4]=0xDEADBEEF after 3rd edge. wb_W=0 during stall edges.
- Load: MemRead=1, alu_result=0x10, control_W=2'b11, wn=5 → stall 2 cycles. After completion edge: wb_rd=0xDEADBEEF, wb_wn=5, wb_W=2'b11.
- Branch, no memory op: branch=1, zero=1, branch_pc=0x40 → pcsrc=1, branch_target=0x40, stall=0. With zero=0 → pcsrc=0.
- Wrap/alignment, MEM_WORDS=256: store 0x1 at alu_result=0x403, then load alu_result=0x000 → wb_rd=0x1.
- Reset mid-op: assert rst during 1st stall cycle of a store to 0x20 → stall=0 and wb_* =0 immediately. mem[8] unchanged. Next instruction completes normally.
- WAIT_CYCLES=0 regression: 4 consecutive loads/stores → stall never asserted. One MEM/WB update per cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined CPU.
//   Resolves branches, performs loads and stores against an internal word
//   array with WAIT_CYCLES extra cycles per access, and registers results
//   into the MEM/WB pipeline register. Raises stall while an access is in flight.
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   alu_result, store_data   EX/MEM address/ALU result and store data
//   wn, control_W            destination reg and WB control ([1] RegWrite, [0] MemtoReg)
//   branch, zero, branch_pc  branch resolution inputs
//   MemWrite, MemRead        memory request
//   pcsrc, branch_target     branch outcome to IF
//   stall                    freeze upstream stages this cycle
//   wb_rd, wb_alu, wb_wn, wb_W   MEM/WB register outputs
module mem_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  wn,
  input  logic [1:0]  control_W,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_pc,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [31:0] wb_rd,
  output logic [31:0] wb_alu,
  output logic [4:0]  wb_wn,
  output logic [1:0]  wb_W
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  // Counter only ever holds WAIT_CYCLES-1 down to 0.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        wb_rd_q, wb_rd_d;
  logic [31:0]        wb_alu_q, wb_alu_d;
  logic [4:0]         wb_wn_q, wb_wn_d;
  logic [1:0]         wb_W_q, wb_W_d;
  logic [31:0]        mem_q [MEM_WORDS];

  logic               access;
  logic               stall_raw;
  logic               complete;
  logic [IDX_W-1:0]   idx;

  assign access = MemRead | MemWrite;
  // Byte address -> word index; upper bits dropped so addresses wrap.
  assign idx    = alu_result[IDX_W+1:2];

  // Access sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    complete  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && (WAIT_CYCLES > 0)) begin
          stall_raw = 1'b1;
          cnt_d     = CNT_W'(WAIT_CYCLES - 1);
          state_d   = S_WAIT;
        end else begin
          complete  = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else begin
          complete  = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM/WB register: real update on completion, bubble (RegWrite/MemtoReg
  // cleared, data held) on stall cycles so the instruction writes back once.
  always_comb begin
    wb_rd_d  = wb_rd_q;
    wb_alu_d = wb_alu_q;
    wb_wn_d  = wb_wn_q;
    wb_W_d   = '0;
    if (complete) begin
      wb_rd_d  = MemRead ? mem_q[idx] : 32'h0;  // read-before-write
      wb_alu_d = alu_result;
      wb_wn_d  = wn;
      wb_W_d   = control_W;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_q  <= '0;
      wb_alu_q <= '0;
      wb_wn_q  <= '0;
      wb_W_q   <= '0;
    end else begin
      wb_rd_q  <= wb_rd_d;
      wb_alu_q <= wb_alu_d;
      wb_wn_q  <= wb_wn_d;
      wb_W_q   <= wb_W_d;
    end
  end

  // Data array is never cleared; a store held under reset is dropped.
  always_ff @(posedge clk) begin
    if (complete && MemWrite && !rst)
      mem_q[idx] <= store_data;
  end

  assign stall         = stall_raw & ~rst;
  assign pcsrc         = branch & zero & ~stall & ~rst;
  assign branch_target = branch_pc;
  assign wb_rd         = wb_rd_q;
  assign wb_alu        = wb_alu_q;
  assign wb_wn         = wb_wn_q;
  assign wb_W          = wb_W_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a WAIT_CYCLES=2 instance driven from a vector table
// with a writeback scoreboard, plus a WAIT_CYCLES=0 instance for the
// back-to-back no-stall case and a reset-during-access sequence.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic [31:0] alu_result, store_data, branch_pc;
  logic [4:0]  wn;
  logic [1:0]  control_W;
  logic        branch, zero, MemWrite, MemRead;
  logic        pcsrc, stall;
  logic [31:0] branch_target, wb_rd, wb_alu;
  logic [4:0]  wb_wn;
  logic [1:0]  wb_W;

  mem_stage #(.MEM_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .store_data(store_data),
    .wn(wn), .control_W(control_W), .branch(branch), .zero(zero),
    .branch_pc(branch_pc), .MemWrite(MemWrite), .MemRead(MemRead),
    .pcsrc(pcsrc), .branch_target(branch_target), .stall(stall),
    .wb_rd(wb_rd), .wb_alu(wb_alu), .wb_wn(wb_wn), .wb_W(wb_W)
  );

  // WAIT_CYCLES=0 instance
  logic [31:0] z_alu, z_sd, z_bpc;
  logic [4:0]  z_wn;
  logic [1:0]  z_cw;
  logic        z_br, z_zr, z_we, z_re;
  logic        z_pcsrc, z_stall;
  logic [31:0] z_bt, z_rd, z_walu;
  logic [4:0]  z_wwn;
  logic [1:0]  z_wW;

  mem_stage #(.MEM_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .alu_result(z_alu), .store_data(z_sd),
    .wn(z_wn), .control_W(z_cw), .branch(z_br), .zero(z_zr),
    .branch_pc(z_bpc), .MemWrite(z_we), .MemRead(z_re),
    .pcsrc(z_pcsrc), .branch_target(z_bt), .stall(z_stall),
    .wb_rd(z_rd), .wb_alu(z_walu), .wb_wn(z_wwn), .wb_W(z_wW)
  );

  typedef struct {
    logic        we, re;
    logic [31:0] addr, data;
    logic [4:0]  wn;
    logic [1:0]  cw;
    logic        br, zr;
    logic [31:0] bpc;
    logic [31:0] exp_rd;
    int          exp_stalls;
    logic        exp_pcsrc;
  } vec_t;

  typedef struct {
    logic [31:0] rd, alu;
    logic [4:0]  wn;
    logic [1:0]  w;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] data, input logic [4:0] w, input logic [1:0] cw,
                              input logic br, input logic zr, input logic [31:0] bpc,
                              input logic [31:0] exp_rd, input logic exp_pc);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.data = data; v.wn = w; v.cw = cw;
    v.br = br; v.zr = zr; v.bpc = bpc; v.exp_rd = exp_rd; v.exp_pcsrc = exp_pc;
    v.exp_stalls = (we || re) ? 2 : 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    MemWrite = v.we; MemRead = v.re; alu_result = v.addr; store_data = v.data;
    wn = v.wn; control_W = v.cw; branch = v.br; zero = v.zr; branch_pc = v.bpc;
  endtask

  // Issue one instruction at the next falling edge and follow it to completion.
  task automatic run_vec(input string name, input vec_t v);
    exp_t e, got;
    bit   exp_st;
    @(negedge clk);
    drive(v);
    e.rd = v.exp_rd; e.alu = v.addr; e.wn = v.wn; e.w = v.cw;
    sb.push_back(e);
    for (int c = 0; c <= v.exp_stalls; c++) begin
      exp_st = (c < v.exp_stalls);
      #1;
      chk({name, ".stall"}, 32'(stall), 32'(exp_st));
      chk({name, ".pcsrc"}, 32'(pcsrc), exp_st ? 32'h0 : 32'(v.exp_pcsrc));
      chk({name, ".btgt"}, branch_target, v.bpc);
      @(posedge clk); #1;
      if (exp_st) begin
        chk({name, ".bubble_W"}, 32'(wb_W), 32'h0);
        @(negedge clk);
      end else if (sb.size() == 0) begin
        chk({name, ".sb_empty"}, 32'h1, 32'h0);
      end else begin
        got = sb.pop_front();
        chk({name, ".wb_rd"},  wb_rd,       got.rd);
        chk({name, ".wb_alu"}, wb_alu,      got.alu);
        chk({name, ".wb_wn"},  32'(wb_wn),  32'(got.wn));
        chk({name, ".wb_W"},   32'(wb_W),   32'(got.w));
      end
    end
  endtask

  vec_t tbl[10];

  initial begin
    //          we    re    addr          data          wn  cw     br    zr    bpc    exp_rd        pcsrc
    tbl[0] = mk(1'b1, 1'b0, 32'h10,       32'hDEADBEEF, 5'd9, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0,       1'b0);
    tbl[1] = mk(1'b0, 1'b1, 32'h10,       32'h0,        5'd5, 2'b11, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    tbl[2] = mk(1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 2'b00, 1'b1, 1'b1, 32'h40, 32'h0,       1'b1);
    tbl[3] = mk(1'b0, 1'b0, 32'h4,        32'h0,        5'd0, 2'b00, 1'b1, 1'b0, 32'h40, 32'h0,       1'b0);
    tbl[4] = mk(1'b1, 1'b0, 32'h403,      32'h1,        5'd2, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0,       1'b0);
    tbl[5] = mk(1'b0, 1'b1, 32'h000,      32'h0,        5'd7, 2'b11, 1'b0, 1'b0, 32'h0, 32'h1,       1'b0);
    tbl[6] = mk(1'b1, 1'b1, 32'h10,       32'h12345678, 5'd4, 2'b11, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    tbl[7] = mk(1'b0, 1'b1, 32'h8000_0010, 32'h0,       5'd6, 2'b11, 1'b0, 1'b0, 32'h0, 32'h12345678, 1'b0);
    tbl[8] = mk(1'b0, 1'b0, 32'hABCD,     32'h0,        5'd3, 2'b10, 1'b0, 1'b1, 32'h0, 32'h0,       1'b0);
    tbl[9] = mk(1'b1, 1'b0, 32'h20,       32'hCAFEF00D, 5'd1, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0,       1'b0);

    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    z_alu = '0; z_sd = '0; z_bpc = '0; z_wn = '0; z_cw = '0;
    z_br = 1'b0; z_zr = 1'b0; z_we = 1'b0; z_re = 1'b0;

    // Reset state
    #2;
    chk("rst.stall",  32'(stall), 32'h0);
    chk("rst.wb_rd",  wb_rd,      32'h0);
    chk("rst.wb_alu", wb_alu,     32'h0);
    chk("rst.wb_W",   32'(wb_W),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), tbl[i]);

    // Reset in the first stall cycle of a store to 0x20
    @(negedge clk);
    drive(mk(1'b1, 1'b0, 32'h20, 32'h11111111, 5'd8, 2'b01, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0));
    #1;
    chk("mid.stall_pre", 32'(stall), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid.stall",  32'(stall), 32'h0);
    chk("mid.pcsrc",  32'(pcsrc), 32'h0);
    chk("mid.wb_alu", wb_alu,     32'h0);
    chk("mid.wb_wn",  32'(wb_wn), 32'h0);
    chk("mid.wb_rd",  wb_rd,      32'h0);
    @(posedge clk); #1;
    chk("mid.hold_W", 32'(wb_W),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    @(posedge clk); #1;
    run_vec("post_ld", mk(1'b0, 1'b1, 32'h20, 32'h0, 5'd10, 2'b11, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0));
    run_vec("post_alu", mk(1'b0, 1'b0, 32'h55, 32'h0, 5'd11, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    chk("sb.drained", 32'(sb.size()), 32'h0);

    // WAIT_CYCLES=0: four back-to-back accesses, one MEM/WB update per cycle
    drive(mk(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a, d, er;
      a  = (k[0]) ? 32'hC : 32'h8;
      d  = (k[0]) ? 32'hBBBB0002 : 32'hAAAA0001;
      er = (k >= 2) ? d : 32'h0;
      @(negedge clk);
      z_we = (k < 2); z_re = (k >= 2); z_alu = a; z_sd = d;
      z_wn = 5'(k + 1); z_cw = (k >= 2) ? 2'b11 : 2'b01;
      #1;
      chk($sformatf("z%0d.stall", k), 32'(z_stall), 32'h0);
      @(posedge clk); #1;
      chk($sformatf("z%0d.wb_alu", k), z_walu, a);
      chk($sformatf("z%0d.wb_rd", k),  z_rd,   er);
      chk($sformatf("z%0d.wb_wn", k),  32'(z_wwn), 32'(k + 1));
      chk($sformatf("z%0d.wb_W", k),   32'(z_wW), (k >= 2) ? 32'h3 : 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
